// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and parameter legality check for the
// sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned BCD_NIBBLE_W   = 4;
  localparam int unsigned BCD_ADJ_THRESH = 5;
  localparam int unsigned BCD_ADJ_ADD    = 3;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FIN
  } bcd_state_t;

  // True when DIGITS decimal digits can hold every WIDTH-bit unsigned value.
  function automatic bit bcd_digits_ok(input int unsigned width, input int unsigned digits);
    longint unsigned pow10;
    longint unsigned max_bin;
    pow10 = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      pow10 = pow10 * 10;
    end
    max_bin = (64'd1 << width) - 64'd1;
    return pow10 > max_bin;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: nibbles of 5 or more get +3 before the shift.
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [BCD_NIBBLE_W-1:0] din,
  output logic [BCD_NIBBLE_W-1:0] dout
);

  always_comb begin
    if (din >= BCD_NIBBLE_W'(BCD_ADJ_THRESH)) begin
      dout = din + BCD_NIBBLE_W'(BCD_ADJ_ADD);
    end else begin
      dout = din;
    end
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Define BCD_AUTO_START_EN to also start a conversion whenever BIN_IN changes.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                             CLOCK_50,
  input  logic                             RESET_N,
  input  logic [WIDTH-1:0]                 BIN_IN,
  input  logic                             START,
  output logic                             BUSY,
  output logic                             DONE,
  output logic [BCD_NIBBLE_W*DIGITS-1:0]   BCD_OUT
);

  localparam int unsigned BCD_W = BCD_NIBBLE_W * DIGITS;
  localparam int unsigned SR_W  = BCD_W + WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
    $error("bcd_seq_converter: WIDTH must be in 4..16");
  end
  if (!bcd_digits_ok(WIDTH, DIGITS)) begin : g_bad_digits
    $error("bcd_seq_converter: DIGITS too small for WIDTH");
  end

  bcd_state_t         state, state_nxt;
  logic [SR_W-1:0]    sr, sr_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               busy_nxt, done_nxt;
  logic [BCD_W-1:0]   bcd_nxt;
  logic [BCD_W-1:0]   adj_bcd;
  logic               start_req;

  // Shift register layout: {BCD digits, remaining binary bits}.
  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    bcd_add3_digit u_add3 (
      .din  (sr[WIDTH + d*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
      .dout (adj_bcd[d*BCD_NIBBLE_W +: BCD_NIBBLE_W])
    );
  end

`ifdef BCD_AUTO_START_EN
  logic [WIDTH-1:0] last_bin;

  assign start_req = START || (BIN_IN != last_bin);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      last_bin <= '0;
    end else if (state == IDLE && start_req) begin
      last_bin <= BIN_IN;
    end
  end
`else
  assign start_req = START;
`endif

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    busy_nxt  = BUSY;
    done_nxt  = 1'b0;
    bcd_nxt   = BCD_OUT;
    unique case (state)
      IDLE: begin
        if (start_req) begin
          sr_nxt    = {{BCD_W{1'b0}}, BIN_IN};
          cnt_nxt   = CNT_W'(WIDTH);
          busy_nxt  = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        sr_nxt  = {adj_bcd, sr[WIDTH-1:0]} << 1;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        bcd_nxt   = sr[SR_W-1 -: BCD_W];
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      BCD_OUT <= '0;
    end else begin
      state   <= state_nxt;
      sr      <= sr_nxt;
      cnt     <= cnt_nxt;
      BUSY    <= busy_nxt;
      DONE    <= done_nxt;
      BCD_OUT <= bcd_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Self-checking bench for bcd_seq_converter (8-bit/3-digit and 4-bit/2-digit builds).
module tb_bcd_seq_converter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  bin8;
  logic        start8;
  logic        busy8, done8;
  logic [11:0] bcd8;
  logic [3:0]  bin4;
  logic        start4;
  logic        busy4, done4;
  logic [7:0]  bcd4;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) u_dut8 (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .BIN_IN   (bin8),
    .START    (start8),
    .BUSY     (busy8),
    .DONE     (done8),
    .BCD_OUT  (bcd8)
  );

  bcd_seq_converter #(.WIDTH(4), .DIGITS(2)) u_dut4 (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .BIN_IN   (bin4),
    .START    (start4),
    .BUSY     (busy4),
    .DONE     (done4),
    .BCD_OUT  (bcd4)
  );

  // Reference: decimal digits by repeated division.
  function automatic logic [31:0] to_bcd(input int unsigned v, input int unsigned nd);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < nd; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input logic [7:0] v, input string tag);
    int unsigned n, busy_n;
    bit got;
    bin8 = v;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    busy_n = busy8 ? 1 : 0;
    n = 0;
    got = 1'b0;
    while (!got && n < 30) begin
      tick();
      n++;
      if (busy8) busy_n++;
      if (done8) got = 1'b1;
    end
    chk({tag, "_lat"}, n, 9);
    chk({tag, "_busy"}, busy_n, 9);
    chk({tag, "_bcd"}, bcd8, to_bcd(v, 3));
    tick();
    chk({tag, "_done_1cyc"}, done8, 1'b0);
  endtask

  task automatic run4(input logic [3:0] v);
    int unsigned n;
    bit got;
    bin4 = v;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      if (done4) got = 1'b1;
    end
    chk("w4_lat", n, 5);
    chk("w4_bcd", bcd4, to_bcd(v, 2));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned dones, first_idx, last_idx;
    logic [11:0] seen;
    logic [7:0]  directed [5];
    rst_n = 1'b0;
    bin8 = '0; start8 = 1'b0;
    bin4 = '0; start4 = 1'b0;
    directed = '{8'd255, 8'd9, 8'd10, 8'd99, 8'd100};

    tick(); tick();
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_bcd", bcd8, 12'h000);
    chk("rst_bcd4", bcd4, 8'h00);
    rst_n = 1'b1;
    tick();

    run8(8'd0, "zero");
    foreach (directed[i]) run8(directed[i], "dir");
    for (int i = 0; i < 20; i++) run8(8'($urandom_range(0, 255)), "rand");

    // START again and BIN_IN change while converting are ignored.
    bin8 = 8'd37; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    dones = 0; seen = '0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 3) begin start8 = 1'b1; bin8 = 8'd200; end
      if (i == 4) start8 = 1'b0;
      if (done8) begin dones++; seen = bcd8; end
    end
    chk("midconv_dones", dones, 1);
    chk("midconv_bcd", seen, 12'h037);
    for (int i = 0; i < 14; i++) tick();

    // Asynchronous reset during CONV.
    bin8 = 8'd123; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy8, 1'b0);
    chk("abort_done", done8, 1'b0);
    chk("abort_bcd", bcd8, 12'h000);
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) dones++;
    end
`ifdef BCD_AUTO_START_EN
    chk("abort_post_dones", dones, 1);
`else
    chk("abort_post_dones", dones, 0);
`endif

    // START held high: back-to-back with one IDLE cycle between.
    bin8 = 8'd42; start8 = 1'b1;
    dones = 0; first_idx = 0; last_idx = 0;
    for (int i = 1; i <= 35; i++) begin
      tick();
      if (done8) begin
        if (dones == 0) first_idx = i;
        else chk("b2b_period", i - last_idx, 10);
        last_idx = i;
        dones++;
        chk("b2b_bcd", bcd8, 12'h042);
      end
    end
    start8 = 1'b0;
    chk("b2b_first", first_idx, 10);
    chk("b2b_count", dones, 3);
    for (int i = 0; i < 12; i++) tick();

    // Switch change without START.
    run8(8'd5, "pre_auto");
    bin8 = 8'd6;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) dones++;
    end
`ifdef BCD_AUTO_START_EN
    chk("auto_dones", dones, 1);
    chk("auto_bcd", bcd8, 12'h006);
`else
    chk("auto_dones", dones, 0);
    chk("auto_bcd", bcd8, 12'h005);
`endif

    for (int v = 0; v < 16; v++) run4(4'(v));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
